truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a 16-minterm sweep; sampled only in IDLE.
REQ-004 SHALL have port: abort  input  1  cancel sweep in progress.
REQ-005 SHALL have port: mask  input  16  expected truth table; bit i = expected f for minterm i; captured on start acceptance.
REQ-006 SHALL have port: f_in  input  1  output of the combinational function under test.
REQ-007 SHALL have port: xywz  output  4  drive to function inputs {x,y,w,z}, x = MSB.
REQ-008 SHALL have port: busy  output  1  high in RUN and SETTLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port: result  output  16  sampled f_in per minterm.
REQ-011 SHALL have port: mismatch_cnt  output  5  count of minterms with f_in != mask bit, range 0..16.
REQ-012 SHALL have port: err_valid  output  1  at least one mismatch seen this sweep.
REQ-013 SHALL have port: first_err  output  4  lowest-index mismatching minterm; valid only when err_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, SETTLE (macro only), DONE.
REQ-015 IDLE: start=1 at edge -> RUN; idx<=0; mask latched; result, mismatch_cnt, err_valid, first_err cleared to 0.
REQ-016 SHALL drive xywz = idx in RUN/SETTLE and 4'h0 in IDLE/DONE.
REQ-017 RUN edge: result[idx]<=f_in; on mismatch mismatch_cnt+1; on first mismatch err_valid<=1, first_err<=idx.
REQ-018 RUN edge with idx=15 -> DONE; otherwise idx<=idx+1, no wrap past 15.
REQ-019 DONE: done=1 exactly one cycle, busy=0, then unconditionally -> IDLE; start in DONE ignored.
REQ-020 Without macro: done asserts on 17th cycle after the start-accept edge (16 RUN cycles + DONE).
REQ-021 start while busy or in DONE SHALL be ignored; no restart, no stat clear.
REQ-022 abort=1 in RUN/SETTLE -> IDLE next edge, no done pulse, no sample that edge; partial stats held; abort has priority over sampling and idx=15 completion.
REQ-023 abort in IDLE/DONE SHALL have no effect; abort and start together in IDLE: abort wins, stay IDLE.
REQ-024 result, mismatch_cnt, err_valid, first_err SHALL hold after DONE/abort until next accepted start.

Reset
REQ-025 rst_n=0 at edge SHALL force IDLE, idx=0, xywz=0, busy=0, done=0, result=0, mismatch_cnt=0, err_valid=0, first_err=0, latched mask=0.
REQ-026 Reset mid-sweep SHALL discard the sweep with no done pulse; reset has priority over start and abort.

Configuration
REQ-027 Macro TTS_SETTLE_EN defined: each minterm takes 2 cycles -- SETTLE drives xywz=idx with no sampling, then RUN samples per REQ-017; done on 33rd cycle after start acceptance; abort honoured in SETTLE.
REQ-028 Macro undefined: SETTLE state absent; one minterm per cycle per REQ-020.

Verification
REQ-029 mask=16'h6104, f_in = correct SoP(2,8,13,14) of xywz, start pulse -> done at cycle 17, result=16'h6104, mismatch_cnt=0, err_valid=0.
REQ-030 mask=16'h0000, same f_in -> result=16'h6104, mismatch_cnt=4, err_valid=1, first_err=4'd2.
REQ-031 mask=16'hFFFF, f_in tied 0 -> mismatch_cnt=16, first_err=0; second start with mask=16'h0000 -> stats cleared, mismatch_cnt=0.
REQ-032 abort at the edge where idx=5 -> no done, busy=0 next cycle, result bits [15:5]=0, start pulse during sweep ignored.
REQ-033 rst_n=0 at idx=9 -> all outputs 0 next cycle; start afterwards runs full sweep normally.
REQ-034 With TTS_SETTLE_EN, REQ-029 stimulus -> done at cycle 33, identical result values.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps 16 minterms of a 4-input function and compares f_in against an expected table
// Optional TTS_SETTLE_EN inserts a non-sampling SETTLE cycle before each RUN sample.
module truth_table_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] mask,
    input  logic        f_in,
    output logic [3:0]  xywz,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  mismatch_cnt,
    output logic        err_valid,
    output logic [3:0]  first_err
);

`ifdef TTS_SETTLE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_DONE} state_t;
    localparam state_t FIRST_STATE = S_SETTLE;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam state_t FIRST_STATE = S_RUN;
`endif

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_mask;
    logic [3:0]  r_xywz;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_result;
    logic [4:0]  r_mismatch_cnt;
    logic        r_err_valid;
    logic [3:0]  r_first_err;
    logic        w_mismatch;

    assign w_mismatch = f_in ^ r_mask[r_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= 4'd0;
            r_mask         <= 16'h0000;
            r_xywz         <= 4'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= 16'h0000;
            r_mismatch_cnt <= 5'd0;
            r_err_valid    <= 1'b0;
            r_first_err    <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort beats start when both arrive in IDLE
                    if (start && !abort) begin
                        r_state        <= FIRST_STATE;
                        r_idx          <= 4'd0;
                        r_mask         <= mask;
                        r_xywz         <= 4'd0;
                        r_busy         <= 1'b1;
                        r_result       <= 16'h0000;
                        r_mismatch_cnt <= 5'd0;
                        r_err_valid    <= 1'b0;
                        r_first_err    <= 4'd0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 4'd0;
                        r_xywz  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result[r_idx] <= f_in;
                        if (w_mismatch) begin
                            r_mismatch_cnt <= r_mismatch_cnt + 5'd1;
                            if (!r_err_valid) begin
                                r_err_valid <= 1'b1;
                                r_first_err <= r_idx;
                            end
                        end
                        if (r_idx == 4'd15) begin
                            r_state <= S_DONE;
                            r_idx   <= 4'd0;
                            r_xywz  <= 4'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FIRST_STATE;
                            r_idx   <= r_idx + 4'd1;
                            r_xywz  <= r_idx + 4'd1;
                        end
                    end
                end
`ifdef TTS_SETTLE_EN
                S_SETTLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= 4'd0;
                        r_xywz  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign xywz         = r_xywz;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign mismatch_cnt = r_mismatch_cnt;
    assign err_valid    = r_err_valid;
    assign first_err    = r_first_err;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - vector table, corner sequences and random sweeps against a truth-table model
module tb_truth_table_sequencer;

`ifdef TTS_SETTLE_EN
    localparam int CYC = 2;
`else
    localparam int CYC = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] mask;
    logic        f_in;
    logic [3:0]  xywz;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  mismatch_cnt;
    logic        err_valid;
    logic [3:0]  first_err;

    logic [15:0] ftab;
    int          n_checks;
    int          n_errors;

    truth_table_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mask         (mask),
        .f_in         (f_in),
        .xywz         (xywz),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mismatch_cnt (mismatch_cnt),
        .err_valid    (err_valid),
        .first_err    (first_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The function under test is just a lookup of its own truth table.
    always_comb f_in = ftab[xywz];

    typedef struct {
        logic [15:0] m;
        logic [15:0] f;
        logic [15:0] exp_result;
        int          exp_cnt;
        logic        exp_ev;
        logic [3:0]  exp_fe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string tag, input logic [15:0] er, input int ec,
                               input logic ev, input logic [3:0] fe);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(ec));
        check({tag, ".err_valid"}, 32'(err_valid), 32'(ev));
        if (ev) check({tag, ".first_err"}, 32'(first_err), 32'(fe));
    endtask

    // Reference: first n minterms are sampled; compare each against the expected table.
    task automatic model(input logic [15:0] m, input logic [15:0] f, input int n,
                         output logic [15:0] er, output int ec, output logic ev, output logic [3:0] fe);
        er = 16'h0; ec = 0; ev = 1'b0; fe = 4'h0;
        for (int i = 0; i < n; i++) begin
            er[i] = f[i];
            if (f[i] != m[i]) begin
                if (!ev) fe = 4'(i);
                ev = 1'b1;
                ec++;
            end
        end
    endtask

    // Called at a negedge in IDLE. abort_idx / rst_idx < 0 disables that event.
    task automatic run_sweep(input string tag, input logic [15:0] m, input logic [15:0] f,
                             input int abort_idx, input int rst_idx, input bit poke_start,
                             output logic [15:0] er, output int ec, output logic ev, output logic [3:0] fe);
        int done_at;
        int sampled;
        bit busy_ok;
        bit xywz_ok;
        bit aborted;
        bit done_seen;
        ftab = f; mask = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mask = ~m;
        done_at = 0; busy_ok = 1; xywz_ok = 1; aborted = 0; sampled = 16;
        for (int n = 1; n <= 16 * CYC + 8; n++) begin
            if (done) begin done_at = n; break; end
            if (!busy) busy_ok = 0;
            if (xywz != 4'((n - 1) / CYC)) xywz_ok = 0;
            start = poke_start && (n == 3);
            if (rst_idx >= 0 && (n - 1) / CYC == rst_idx) begin
                rst_n = 1'b0;
                start = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                check({tag, ".rst_outputs"},
                      {xywz, busy, done, result, mismatch_cnt, err_valid, first_err}, 32'h0);
                check({tag, ".rst_busy_hold"}, 32'(busy_ok), 32'd1);
                er = 16'h0; ec = 0; ev = 1'b0; fe = 4'h0;
                return;
            end
            if (abort_idx >= 0 && (n - 1) / CYC == abort_idx && n % CYC == 0) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                sampled = abort_idx;
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, ".xywz_seq"}, 32'(xywz_ok), 32'd1);
        if (aborted) begin
            check({tag, ".abort_busy"}, 32'(busy), 32'd0);
            check({tag, ".abort_xywz"}, 32'(xywz), 32'd0);
            done_seen = done;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done) done_seen = 1;
            end
            check({tag, ".abort_no_done"}, 32'(done_seen), 32'd0);
        end else begin
            check({tag, ".done_cycle"}, 32'(done_at), 32'(16 * CYC + 1));
            check({tag, ".done_busy"}, 32'(busy), 32'd0);
            if (poke_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, ".done_pulse"}, {busy, done}, 32'd0);
            @(negedge clk);
            check({tag, ".no_restart"}, {busy, done}, 32'd0);
        end
        model(m, f, sampled, er, ec, ev, fe);
    endtask

    vec_t        vecs[6];
    logic [15:0] er;
    int          ec;
    logic        ev;
    logic [3:0]  fe;

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = 16'h0; ftab = 16'h0;

        vecs[0] = '{16'h6104, 16'h6104, 16'h6104, 0,  1'b0, 4'd0};
        vecs[1] = '{16'h0000, 16'h6104, 16'h6104, 4,  1'b1, 4'd2};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16, 1'b1, 4'd0};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 4'd0};
        vecs[4] = '{16'h8000, 16'h0000, 16'h0000, 1,  1'b1, 4'd15};
        vecs[5] = '{16'h6104, 16'hFFFF, 16'hFFFF, 12, 1'b1, 4'd0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {xywz, busy, done, result, mismatch_cnt, err_valid, first_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_wins", {busy, xywz}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].m, vecs[i].f, -1, -1, i == 2, er, ec, ev, fe);
            check_stats($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_cnt,
                        vecs[i].exp_ev, vecs[i].exp_fe);
        end

        run_sweep("abort5", 16'h0000, 16'hFFFF, 5, -1, 1, er, ec, ev, fe);
        check_stats("abort5", 16'h001F, 5, 1'b1, 4'd0);
        check("abort5.upper", 32'(result[15:5]), 32'd0);

        run_sweep("rst9", 16'h0000, 16'h6104, -1, 9, 0, er, ec, ev, fe);
        run_sweep("after_rst", 16'h0000, 16'h6104, -1, -1, 0, er, ec, ev, fe);
        check_stats("after_rst", 16'h6104, 4, 1'b1, 4'd2);

        for (int r = 0; r < 24; r++) begin
            logic [15:0] rm;
            logic [15:0] rf;
            int          ab;
            rm = 16'($urandom);
            rf = 16'($urandom);
            if (r % 4 == 3) rf = rm ^ (16'h1 << $urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_sweep($sformatf("rnd%0d", r), rm, rf, ab, -1, 1'($urandom_range(0, 1)), er, ec, ev, fe);
            check_stats($sformatf("rnd%0d", r), er, ec, ev, fe);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
